bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble, one bit per clock) for the display path of the calculator datapath. It takes a binary result, such as the product of two 2-digit operands (max 99×99 = 9801), and returns packed BCD digits for the 7-segment driver. It is the output-side counterpart of the BCD-to-binary input converter. It uses a single-cycle start / done-pulse handshake.

---
 rtl/bin_to_bcd_seq.sv | 168 ++++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-packed-BCD converter (double dabble,
// one input bit per clock) with a start / done-pulse handshake.
// Optional range check against 10^DIGITS-1: define BIN_TO_BCD_OVF_CHECK_EN.
// Without it, error is tied low and results wrap modulo 10^DIGITS.

// Per-digit adjust: a nibble of 5..9 gets +3 so the following left shift
// carries into the next decimal digit.
module bin_to_bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  assign d_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;
endmodule

module bin_to_bcd_seq #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  sh_q,    sh_d;
  logic [BW-1:0]     scr_q,   scr_d;
  logic [CW-1:0]     cnt_q,   cnt_d;
  logic [BW-1:0]     bcd_q,   bcd_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;

  // Adjusted scratch digits, one add3 cell per digit, all in parallel.
  logic [DIGITS-1:0][3:0] scr_adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bin_to_bcd_add3 u_add3 (
      .d_i (scr_q[4*g +: 4]),
      .d_o (scr_adj[g])
    );
  end

  // Combined {scratch, shift} register shifted left by one; the bit leaving
  // the top digit falls off, giving the mod 10^DIGITS behaviour.
  logic [BW+WIDTH-1:0] cat, cat_sh;
  assign cat    = {scr_adj, sh_q};
  assign cat_sh = cat << 1;

`ifdef BIN_TO_BCD_OVF_CHECK_EN
  // 10^n as a 64-bit constant; the range check assumes WIDTH <= 64.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS) - 64'd1;

  logic ovf_w;
  logic ovf_q, ovf_d;
  logic err_q, err_d;
  assign ovf_w = (64'(bin_in) > LIMIT);
`endif

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef BIN_TO_BCD_OVF_CHECK_EN
    ovf_d   = ovf_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sh_d    = bin_in;
          scr_d   = '0;
          cnt_d   = CW'(WIDTH);
          busy_d  = 1'b1;
          state_d = S_SHIFT;
`ifdef BIN_TO_BCD_OVF_CHECK_EN
          err_d   = 1'b0;
          ovf_d   = ovf_w;
          // Out-of-range input skips conversion; scratch is already zero.
          if (ovf_w) state_d = S_DONE;
`endif
        end
      end
      S_SHIFT: begin
        {scr_d, sh_d} = cat_sh;
        cnt_d         = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        bcd_d   = scr_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
`ifdef BIN_TO_BCD_OVF_CHECK_EN
        err_d   = ovf_q;
`endif
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef BIN_TO_BCD_OVF_CHECK_EN
  // Overflow tracking and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end
  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  assign bcd_out = bcd_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq at default parameters; expectations
// follow BIN_TO_BCD_OVF_CHECK_EN when the macro is defined.
module tb_bin_to_bcd_seq;

  localparam int WIDTH  = 14;
  localparam int DIGITS = 4;
`ifdef BIN_TO_BCD_OVF_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] bin_in = '0;
  logic [15:0] bcd_out;
  logic        busy, done, error;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .bcd_out (bcd_out),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;   // bin mod 10000 in BCD
    bit          ovf;   // bin > 9999
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One conversion; optionally re-pulses start (bin_in=81) at cycle inj.
  task automatic conv(input logic [13:0] v, input int inj, output int lat,
                      output logic [15:0] bcd, output logic err, output bit busy_ok);
    int cyc;
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bin_in = ~v;
    busy_ok = (busy === 1'b1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (inj > 0 && cyc == inj) begin start = 1'b1; bin_in = 14'd81; end
      if (inj > 0 && cyc == inj + 1) start = 1'b0;
      if (done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
    end
    if (done === 1'b1 && busy !== 1'b0) busy_ok = 1'b0;
    lat = cyc;
    bcd = bcd_out;
    err = error;
  endtask

  initial begin
    vec_t        vecs[11];
    int          lat;
    logic [15:0] bcd;
    logic        err;
    bit          bok;
    int          dc0;

    vecs[0]  = '{14'd9801,  16'h9801, 1'b0};
    vecs[1]  = '{14'd0,     16'h0000, 1'b0};
    vecs[2]  = '{14'd9999,  16'h9999, 1'b0};
    vecs[3]  = '{14'd47,    16'h0047, 1'b0};
    vecs[4]  = '{14'd123,   16'h0123, 1'b0};
    vecs[5]  = '{14'd1,     16'h0001, 1'b0};
    vecs[6]  = '{14'd10,    16'h0010, 1'b0};
    vecs[7]  = '{14'd5,     16'h0005, 1'b0};
    vecs[8]  = '{14'd10000, 16'h0000, 1'b1};
    vecs[9]  = '{14'd12345, 16'h2345, 1'b1};
    vecs[10] = '{14'd16383, 16'h6383, 1'b1};

    // Reset state
    #12;
    chk("rst_bcd",  32'(bcd_out), 32'h0);
    chk("rst_busy", 32'(busy),    32'h0);
    chk("rst_done", 32'(done),    32'h0);
    chk("rst_err",  32'(error),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven conversions
    for (int i = 0; i < 11; i++) begin
      bit oe;
      oe = vecs[i].ovf && OVF_EN;
      conv(vecs[i].bin, 0, lat, bcd, err, bok);
      chk($sformatf("v%0d_lat", i),  32'(lat), oe ? 32'd1 : 32'd15);
      chk($sformatf("v%0d_bcd", i),  32'(bcd), oe ? 32'h0 : 32'(vecs[i].bcd));
      chk($sformatf("v%0d_err", i),  32'(err), 32'(oe));
      chk($sformatf("v%0d_busy", i), 32'(bok), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pulse", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_hold", i),  32'(bcd_out), oe ? 32'h0 : 32'(vecs[i].bcd));
    end

    // Back-to-back with minimum spacing
    dc0 = done_cnt;
    conv(14'd0, 0, lat, bcd, err, bok);
    chk("b2b0_bcd", 32'(bcd), 32'h0000);
    conv(14'd9999, 0, lat, bcd, err, bok);
    chk("b2b1_bcd", 32'(bcd), 32'h9999);
    chk("b2b1_lat", 32'(lat), 32'd15);
    repeat (5) @(posedge clk);
    #1;
    chk("b2b_dones", 32'(done_cnt - dc0), 32'd2);

    // Start during SHIFT is ignored
    dc0 = done_cnt;
    conv(14'd47, 5, lat, bcd, err, bok);
    chk("ign_bcd", 32'(bcd), 32'h0047);
    chk("ign_lat", 32'(lat), 32'd15);
    repeat (20) @(posedge clk);
    #1;
    chk("ign_dones", 32'(done_cnt - dc0), 32'd1);
    chk("ign_busy",  32'(busy), 32'd0);

    // Asynchronous reset mid-conversion (bcd_out holds 0x0047 beforehand)
    @(negedge clk);
    start  = 1'b1;
    bin_in = 14'd9801;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_bcd",  32'(bcd_out), 32'h0);
    chk("arst_busy", 32'(busy),    32'h0);
    chk("arst_done", 32'(done),    32'h0);
    chk("arst_err",  32'(error),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    conv(14'd123, 0, lat, bcd, err, bok);
    chk("post_bcd",  32'(bcd), 32'h0123);
    chk("post_lat",  32'(lat), 32'd15);
    chk("post_busy", 32'(bok), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
